// File: rtl/iotdf_pkg.sv
// Shared definitions for the IoT data filter front end: word geometry,
// filter function encodings and the feeder state type.
package iotdf_pkg;
  localparam int WORD_W         = 128;
  localparam int BYTES_PER_WORD = 16;
  localparam int BYTE_CNT_W     = $clog2(BYTES_PER_WORD);

  typedef enum logic [2:0] {
    FN_NONE     = 3'd0,
    FN_MAX      = 3'd1,
    FN_MIN      = 3'd2,
    FN_AVG      = 3'd3,
    FN_EXTRACT  = 3'd4,
    FN_EXCLUDE  = 3'd5,
    FN_PEAK_MAX = 3'd6,
    FN_PEAK_MIN = 3'd7
  } fn_sel_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_e;
endpackage

// File: rtl/iotdf_word_fifo.sv
// Two-entry 128-bit word buffer with synchronous flush; the caller only
// pushes when not full and only pops when not empty.
module iotdf_word_fifo
  import iotdf_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              push,
  input  logic [WORD_W-1:0] push_data,
  input  logic              pop,
  output logic [WORD_W-1:0] head,
  output logic [1:0]        count
);
  logic [WORD_W-1:0] mem_q [2];
  logic [WORD_W-1:0] mem_d [2];
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop) rd_ptr_d = ~rd_ptr_q;
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
endmodule

// File: rtl/iotdf_feeder.sv
// Buffers sensor words and serializes them MSB byte first into the filter,
// grouping words into rounds that share one fn_sel value.
module iotdf_feeder
  import iotdf_pkg::*;
#(
  parameter int WORDS_PER_ROUND = 8,
  parameter int DEPTH           = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              s_valid,
  input  logic [WORD_W-1:0] s_data,
  output logic              s_ready,
  input  logic [2:0]        cfg_fn_sel,
  input  logic              busy,
  output logic              in_en,
  output logic [7:0]        iot_in,
  output logic [2:0]        fn_sel,
  output logic              round_done
);
  localparam int              WC_W      = $clog2(WORDS_PER_ROUND);
  localparam logic [WC_W-1:0] LAST_WORD = WC_W'(WORDS_PER_ROUND - 1);

  state_e                state_q, state_d;
  logic [BYTE_CNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [WC_W-1:0]       word_cnt_q, word_cnt_d, word_cnt_nxt;
  logic [WORD_W-1:0]     shreg_q, shreg_d;
  logic                  in_en_q, in_en_d;
  logic [7:0]            iot_in_q, iot_in_d;
  fn_sel_e               fn_sel_q, fn_sel_d;
  logic                  round_done_q, round_done_d;

  logic [WORD_W-1:0] head;
  logic [1:0]        fifo_count;
  logic              push, load, word_end;

  assign s_ready  = (fifo_count != 2'(DEPTH));
  assign push     = s_valid && s_ready;
  assign word_end = (state_q == ST_STREAM) && (byte_cnt_q == '0);
  // A new word may start from IDLE or straight after byte 0 of the previous one.
  assign load     = !clr && (fifo_count != 2'd0) && !busy &&
                    ((state_q == ST_IDLE) || word_end);

  iotdf_word_fifo u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .push      (push),
    .push_data (s_data),
    .pop       (load),
    .head      (head),
    .count     (fifo_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      byte_cnt_q   <= '1;
      word_cnt_q   <= '0;
      in_en_q      <= 1'b0;
      iot_in_q     <= 8'd0;
      fn_sel_q     <= FN_NONE;
      round_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      word_cnt_q   <= word_cnt_d;
      in_en_q      <= in_en_d;
      iot_in_q     <= iot_in_d;
      fn_sel_q     <= fn_sel_d;
      round_done_q <= round_done_d;
    end
  end

  always_ff @(posedge clk) begin
    shreg_q <= shreg_d;
  end

  always_comb begin
    state_d = state_q;
    if (clr)           state_d = ST_IDLE;
    else if (load)     state_d = ST_STREAM;
    else if (word_end) state_d = ST_IDLE;
  end

  always_comb begin
    byte_cnt_d   = byte_cnt_q;
    word_cnt_d   = word_cnt_q;
    shreg_d      = shreg_q;
    in_en_d      = in_en_q;
    iot_in_d     = iot_in_q;
    fn_sel_d     = fn_sel_q;
    round_done_d = round_done_q;
    word_cnt_nxt = word_end ? (word_cnt_q + WC_W'(1)) : word_cnt_q;
    if (clr) begin
      byte_cnt_d   = '1;
      word_cnt_d   = '0;
      in_en_d      = 1'b0;
      round_done_d = 1'b0;
    end else if (load) begin
      shreg_d      = head << 8;
      iot_in_d     = head[WORD_W-1 -: 8];
      in_en_d      = 1'b1;
      byte_cnt_d   = '1;
      word_cnt_d   = word_cnt_nxt;
      round_done_d = 1'b0;
      // fn_sel is only sampled on the first word of a round.
      if (word_cnt_nxt == '0) fn_sel_d = fn_sel_e'(cfg_fn_sel);
    end else if (word_end) begin
      byte_cnt_d   = '1;
      word_cnt_d   = word_cnt_nxt;
      in_en_d      = 1'b0;
      round_done_d = 1'b0;
    end else if (state_q == ST_STREAM) begin
      shreg_d      = shreg_q << 8;
      iot_in_d     = shreg_q[WORD_W-1 -: 8];
      byte_cnt_d   = byte_cnt_q - BYTE_CNT_W'(1);
      round_done_d = (byte_cnt_q == BYTE_CNT_W'(1)) && (word_cnt_q == LAST_WORD);
    end
  end

  assign in_en      = in_en_q;
  assign iot_in     = iot_in_q;
  assign fn_sel     = fn_sel_q;
  assign round_done = round_done_q;
endmodule
